// File: rtl/sram_arbiter.sv
// Shares one SRAM between a free-running target (priority) and a host port.
// Host reads are built only when SRAM_ARB_HOST_READ_EN is defined; otherwise reads are acked with zero data.
module sram_arbiter #(
  parameter int HOST_STROBE_CYCLES = 2,
  parameter int TGT_IDLE_CYCLES    = 2
) (
  input  logic        clk24MHz,
  input  logic        rst,
  input  logic        tgt_nCE,
  input  logic        tgt_nOEL,
  input  logic        tgt_nOEH,
  input  logic [17:0] tgt_addr,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [17:0] host_addr,
  input  logic [15:0] host_wdata,
  input  logic [1:0]  host_be,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic        host_busy,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_i,
  output logic        sram_nCS,
  output logic        sram_nWE,
  output logic        sram_nOE,
  output logic        sram_nUB,
  output logic        sram_nLB,
  output logic        target_dbusbuf_en,
  output logic        collision,
  input  logic        collision_clr
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

  localparam logic [3:0] IDLE_MAX = 4'(TGT_IDLE_CYCLES);
  localparam logic [3:0] STB_LOAD = 4'(HOST_STROBE_CYCLES - 1);

  state_e      state_q, state_d;
  logic        nce_meta_q, nce_meta_d, nce_s_q, nce_s_d;
  logic [3:0]  idle_cnt_q, idle_cnt_d, stb_cnt_q, stb_cnt_d;
  logic        we_q, we_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic        ack_q, ack_d, coll_q, coll_d;
  logic        accept, last_strobe;

  assign last_strobe = (state_q == STROBE) && (stb_cnt_q == 4'd0);
  // ack_q blocks re-acceptance during the single-cycle read ack taken from IDLE
  assign accept = host_req && (idle_cnt_q == IDLE_MAX) && !ack_q;

  always_comb begin
    state_d    = state_q;
    stb_cnt_d  = stb_cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    ack_d      = 1'b0;
    nce_meta_d = tgt_nCE;
    nce_s_d    = nce_meta_q;
    if (!nce_s_q)                  idle_cnt_d = 4'd0;
    else if (idle_cnt_q == IDLE_MAX) idle_cnt_d = idle_cnt_q;
    else                           idle_cnt_d = idle_cnt_q + 4'd1;
    coll_d = ((state_q != IDLE) && !nce_s_q) || (coll_q && !collision_clr);
    case (state_q)
      IDLE: if (accept) begin
        we_d    = host_we;
        addr_d  = host_addr;
        wdata_d = host_wdata;
        be_d    = host_be;
`ifdef SRAM_ARB_HOST_READ_EN
        state_d = SETUP;
`else
        if (host_we) state_d = SETUP;
        else         ack_d   = 1'b1;
`endif
      end
      SETUP: begin
        state_d   = STROBE;
        stb_cnt_d = STB_LOAD;
      end
      STROBE: if (last_strobe) begin
        state_d = HOLD;
        ack_d   = 1'b1;
      end else begin
        stb_cnt_d = stb_cnt_q - 4'd1;
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk24MHz) begin
    if (rst) begin
      state_q    <= IDLE;
      nce_meta_q <= 1'b1;
      nce_s_q    <= 1'b1;
      idle_cnt_q <= 4'd0;
      stb_cnt_q  <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 18'd0;
      wdata_q    <= 16'd0;
      be_q       <= 2'b00;
      ack_q      <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      nce_meta_q <= nce_meta_d;
      nce_s_q    <= nce_s_d;
      idle_cnt_q <= idle_cnt_d;
      stb_cnt_q  <= stb_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      ack_q      <= ack_d;
      coll_q     <= coll_d;
    end
  end

`ifdef SRAM_ARB_HOST_READ_EN
  logic [15:0] rdata_q, rdata_d;
  always_comb begin
    rdata_d = rdata_q;
    if (last_strobe && !we_q) rdata_d = sram_dq_i;
  end
  always_ff @(posedge clk24MHz) begin
    if (rst) rdata_q <= 16'd0;
    else     rdata_q <= rdata_d;
  end
  assign host_rdata = rdata_q;
`else
  logic unused_dq;
  assign unused_dq  = ^sram_dq_i;
  assign host_rdata = 16'd0;
`endif

  assign host_ack  = ack_q;
  assign host_busy = (state_q != IDLE);
  assign collision = coll_q;

  always_comb begin
    sram_addr         = tgt_addr;
    sram_nCS          = tgt_nCE;
    sram_nOE          = tgt_nCE;
    sram_nUB          = tgt_nOEH;
    sram_nLB          = tgt_nOEL;
    sram_nWE          = 1'b1;
    sram_dq_oe        = 1'b0;
    sram_dq_o         = wdata_q;
    target_dbusbuf_en = !(!tgt_nCE && (!tgt_nOEL || !tgt_nOEH));
    if (state_q != IDLE) begin
      sram_addr         = addr_q;
      sram_nCS          = 1'b0;
      sram_nOE          = 1'b1;
      sram_nUB          = 1'b1;
      sram_nLB          = 1'b1;
      sram_dq_oe        = we_q;
      target_dbusbuf_en = 1'b1;
      if (state_q == STROBE) begin
        sram_nWE = !we_q;
`ifdef SRAM_ARB_HOST_READ_EN
        sram_nOE = we_q;
`endif
        sram_nUB = !be_q[1];
        sram_nLB = !be_q[0];
      end
    end
  end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter HOST_STROBE_CYCLES, default 2, meaning the width of the host nWE/nOE strobe in clocks (legal range 1..15).
REQ-002 SHALL have parameter TGT_IDLE_CYCLES, default 2, meaning the number of consecutive clocks synchronized tgt_nCE must be high before a host access may start (legal range 1..15).
REQ-003 SHALL have one clock and a synchronous, active-high reset, with ports: clk24MHz in 1 (clock); rst in 1 (reset).
REQ-004 SHALL have target ports: tgt_nCE in 1; tgt_nOEL in 1; tgt_nOEH in 1; tgt_addr in 18 (target word address).
REQ-005 SHALL have host ports: host_req in 1; host_we in 1; host_addr in 18; host_wdata in 16; host_be in 2 (bit1 upper, bit0 lower); host_ack out 1; host_rdata out 16; host_busy out 1.
REQ-006 SHALL have SRAM ports: sram_addr out 18; sram_dq_o out 16; sram_dq_oe out 1; sram_dq_i in 16; sram_nCS out 1; sram_nWE out 1; sram_nOE out 1; sram_nUB out 1; sram_nLB out 1.
REQ-007 SHALL have status ports: target_dbusbuf_en out 1 (active low); collision out 1 (sticky); collision_clr in 1.

Function
REQ-008 SHALL double-flop tgt_nCE into nce_s and count consecutive high samples in an idle counter that saturates at TGT_IDLE_CYCLES and clears on any low sample.
REQ-009 SHALL implement states IDLE, SETUP, STROBE, HOLD.
REQ-010 In IDLE, SHALL pass the target through combinationally: sram_addr=tgt_addr, sram_nCS=tgt_nCE, sram_nOE=tgt_nCE, sram_nUB=tgt_nOEH, sram_nLB=tgt_nOEL, sram_nWE=1, sram_dq_oe=0, target_dbusbuf_en=!(!tgt_nCE && (!tgt_nOEL || !tgt_nOEH)).
REQ-011 In IDLE, SHALL go to SETUP when host_req=1 and the idle counter equals TGT_IDLE_CYCLES, latching host_we/addr/wdata/be; otherwise it SHALL stay in IDLE.
REQ-012 In SETUP, STROBE and HOLD, SHALL drive: sram_addr=latched address, sram_nCS=0, and target_dbusbuf_en=1.
REQ-013 SHALL drive sram_dq_oe=latched we and sram_dq_o=latched wdata in SETUP, STROBE and HOLD.
REQ-014 In SETUP, SHALL hold sram_nWE=1, sram_nOE=1, sram_nUB=1 and sram_nLB=1 for exactly 1 clock.
REQ-015 In STROBE, for HOST_STROBE_CYCLES clocks, SHALL assert sram_nWE=0 on writes or sram_nOE=0 on reads, with sram_nUB=!be[1] and sram_nLB=!be[0].
REQ-016 On a read, SHALL capture sram_dq_i into host_rdata on the last STROBE clock; host_rdata SHALL hold its value until the next read captures new data.
REQ-017 In HOLD, SHALL deassert all strobes and byte enables while keeping address and data driven, pulse host_ack=1 for exactly 1 clock, and return to IDLE.
REQ-018 Latency from host_req accepted to host_ack SHALL be 2+HOST_STROBE_CYCLES clocks (4 at default); host_req is not sampled again until the clock after host_ack.
REQ-019 A host_be=2'b00 access SHALL still run the full sequence and ack, with no byte enables asserted.
REQ-020 A host access, once started, SHALL complete and not be aborted by target activity.
REQ-021 SHALL set collision if nce_s=0 on any clock in SETUP, STROBE or HOLD; collision_clr SHALL clear it, and simultaneous set and clear SHALL leave it set.
REQ-022 host_busy SHALL be 1 in SETUP, STROBE and HOLD, and 0 in IDLE.
REQ-023 The strobe counter SHALL be 4 bits and load HOST_STROBE_CYCLES-1 on entry to STROBE.

Reset
REQ-024 While rst=1, SHALL force state IDLE, host_ack=0, host_rdata=0, collision=0, the idle counter at 0, and the synchronizer flops at 1.
REQ-025 rst asserted mid-access SHALL return the block to IDLE on the next edge; a partial SRAM write is permitted, and no ack SHALL be issued.

Configuration
REQ-026 Macro SRAM_ARB_HOST_READ_EN SHALL control host reads.
REQ-027 With SRAM_ARB_HOST_READ_EN defined, host reads SHALL behave per REQ-015/016.
REQ-028 Without SRAM_ARB_HOST_READ_EN, a read request (host_we=0) SHALL be acked the clock after acceptance without leaving IDLE, host_rdata SHALL be held at 0, sram_nOE SHALL never be driven low by the host path, and the host_rdata capture logic SHALL be removed.

Verification
REQ-029 Bench SHALL cover idle write: tgt_nCE=1, write addr 0x00123, data 0xBEEF, be=11 -> nWE low for 2 clocks, nUB=nLB=0, ack at clock 4, dq_oe high only over SETUP..HOLD.
REQ-030 Bench SHALL cover readback: sram_dq_i=0x5A5A, read addr 0x3FFFF -> host_rdata=0x5A5A at ack (macro defined), or 0x0000 with 1-clock ack (macro undefined).
REQ-031 Bench SHALL cover target priority: tgt_nCE low, host_req high -> no SETUP until nCE has been high for 2 synchronized clocks, with target pass-through meanwhile.
REQ-032 Bench SHALL cover collision: tgt_nCE falls during STROBE -> access completes, collision=1, target_dbusbuf_en=1 until HOLD ends, then collision_clr -> collision=0.
REQ-033 Bench SHALL cover a byte write: be=10, data 0x1234 -> nUB=0, nLB=1 during STROBE.
REQ-034 Bench SHALL cover reset mid-access: rst during STROBE -> next clock in IDLE, nWE=1, ack never pulses, collision=0.
